mmio_if_pio_in: RTL



---
 rtl/mmio_if_pio_in.sv | 116 +++++++++++
 1 files changed

// File: rtl/mmio_if_pio_in.sv
// mmio_if_pio_in: input-direction Avalon-MM slave PIO.
// Synchronizes an external input bus and exposes the live value. Latches
// per-bit edges into a write-1-to-clear capture register and raises a
// maskable level interrupt.
// Optional feature macro: PIO_IN_IRQ_EN enables the IRQMASK register and the
// irq output. Without it, irq is tied low and EDGECAP is for polled use.
// Register map (32-bit read data, zero-extended):
//   0 DATA (RO), 1 reserved, 2 IRQMASK (RW), 3 EDGECAP (RW1C)
module mmio_if_pio_in #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned PRIME_CNT = SYNC_STAGES + 1;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] edge_cap;
  logic [2:0]       prime_cnt;
  logic             primed;
  logic             wr_en;
  logic             unused_bits;

  assign sync_last   = sync_q[SYNC_STAGES-1];
  assign primed      = (prime_cnt == 3'(PRIME_CNT));
  assign wr_en       = chipselect && !write_n;
  // Upper write-data bits are meaningless when WIDTH < 32.
  assign unused_bits = ^writedata;

  // Input synchronizer chain plus the previous-sample register for edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_last;
    end
  end

  // Priming counter: holds off edge detection until the chain has filled,
  // so an input that is already high at reset does not look like an edge.
  always_ff @(posedge clk) begin
    if (reset)        prime_cnt <= '0;
    else if (!primed) prime_cnt <= prime_cnt + 3'd1;
  end

  // Edge selection; unsupported EDGE_TYPE values fall back to any-edge.
  always_comb begin
    edge_vec = '0;
    case (EDGE_TYPE)
      0:       edge_vec = sync_last & ~prev_q;
      1:       edge_vec = ~sync_last & prev_q;
      default: edge_vec = sync_last ^ prev_q;
    endcase
    edge_det = primed ? edge_vec : '0;
  end

  // Write-1 clear mask for EDGECAP.
  always_comb begin
    cap_clr = '0;
    if (wr_en && address == 2'd3) cap_clr = writedata[WIDTH-1:0];
  end

  // Edge capture: a new edge wins over a simultaneous clear of the same bit.
  always_ff @(posedge clk) begin
    if (reset) edge_cap <= '0;
    else       edge_cap <= (edge_cap & ~cap_clr) | edge_det;
  end

`ifdef PIO_IN_IRQ_EN
  logic [WIDTH-1:0] irq_mask;

  // Interrupt mask register.
  always_ff @(posedge clk) begin
    if (reset)                          irq_mask <= '0;
    else if (wr_en && address == 2'd2)  irq_mask <= writedata[WIDTH-1:0];
  end

  // Level interrupt from registered state only.
  always_comb irq = |(edge_cap & irq_mask);
`else
  // No interrupt support: capture register is polled.
  always_comb irq = 1'b0;
`endif

  // Zero-wait-state read mux, zero-extended to 32 bits.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[WIDTH-1:0] = sync_last;
`ifdef PIO_IN_IRQ_EN
      2'd2: readdata[WIDTH-1:0] = irq_mask;
`endif
      2'd3: readdata[WIDTH-1:0] = edge_cap;
      default: readdata = '0;
    endcase
  end

endmodule
